// File: rtl/mccoy_pkg.sv
// -----------------------------------------------------------------------------
// mccoy_pkg
// Shared definitions for the McCoy instruction sequencer slice.
//   INSTR_W        : McCoy instruction width ([5:3] reg/imm, [2:0] opcode)
//   OP_*           : opcode constants understood by the accumulator core
//   seq_state_t    : sequencer FSM state encoding (LOAD / RUN / DONE)
// -----------------------------------------------------------------------------
package mccoy_pkg;

    localparam int INSTR_W = 6;

    localparam logic [2:0] OP_LI  = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SR  = 3'b110;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Extract the opcode field of an instruction.
    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[2:0];
    endfunction

endpackage

// File: rtl/mccoy_prog_mem.sv
// -----------------------------------------------------------------------------
// mccoy_prog_mem
// DEPTH x INSTR_W program register file: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
// Ports:
//   clk      : system clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from the array)
// -----------------------------------------------------------------------------
module mccoy_prog_mem
    import mccoy_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    // Program store write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mccoy_instr_sequencer.sv
// -----------------------------------------------------------------------------
// mccoy_instr_sequencer
// Program buffer and sequencer feeding the McCoy accumulator core instr field.
// Instructions are appended through a valid/ready port while in LOAD; run
// starts issue of one instruction per clock, either one-shot (ending in DONE)
// or looped back to entry 0 when loop_en is high at the wrap point.
// Optional build macro: MCCOY_SEQ_STEP_EN adds a 'step' input that gates
// each issue cycle in RUN (pc holds while step is low).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   wr_valid/wr_instr/wr_ready : program write port
//   run           : start / replay request (level)
//   loop_en       : wrap after the last entry instead of stopping
//   clear         : discard program, return to LOAD
//   instr_out     : registered instruction to the core
//   instr_valid   : instr_out carries a program instruction
//   busy / done   : state is RUN / DONE
//   count         : stored instruction count, 0..DEPTH
//   step          : (MCCOY_SEQ_STEP_EN only) issue enable in RUN
// -----------------------------------------------------------------------------
module mccoy_instr_sequencer
    import mccoy_pkg::*;
#(
    parameter int                 DEPTH      = 8,
    parameter int                 PTR_W      = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0] IDLE_INSTR = 6'b000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic [INSTR_W-1:0] wr_instr,
    output logic               wr_ready,
    input  logic               run,
    input  logic               loop_en,
    input  logic               clear,
`ifdef MCCOY_SEQ_STEP_EN
    input  logic               step,
`endif
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               busy,
    output logic               done,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0]   C_DEPTH    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] C_PC_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    seq_state_t         r_state;
    logic [PTR_W:0]     r_count;
    logic [PTR_W-1:0]   r_pc;
    logic [INSTR_W-1:0] r_instr_out;
    logic               r_instr_valid;

    seq_state_t         w_next_state;
    logic [PTR_W:0]     w_next_count;
    logic [PTR_W:0]     w_post_count;
    logic [PTR_W-1:0]   w_next_pc;
    logic [INSTR_W-1:0] w_next_out;
    logic               w_next_valid;
    logic               w_mem_we;
    logic               w_wr_ready;
    logic               w_issue;
    logic               w_last;
    logic [INSTR_W-1:0] w_rdata;

    // Full buffer never writes, so the low count bits are a valid address.
    mccoy_prog_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_count[PTR_W-1:0]),
        .i_wdata (wr_instr),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

`ifdef MCCOY_SEQ_STEP_EN
    assign w_issue = step;
`else
    assign w_issue = 1'b1;
`endif

    assign w_wr_ready = (r_state == ST_LOAD) && (r_count < C_DEPTH);
    // In RUN count is at least 1, so count-1 never underflows there.
    assign w_last     = ({1'b0, r_pc} == (r_count - C_CNT_ONE));

    // Next-state, pointer, count and issue logic.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_post_count = r_count;
        w_next_pc    = r_pc;
        w_next_out   = IDLE_INSTR;
        w_next_valid = 1'b0;
        w_mem_we     = 1'b0;
        if (clear) begin
            w_next_state = ST_LOAD;
            w_next_count = {(PTR_W+1){1'b0}};
            w_next_pc    = {PTR_W{1'b0}};
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (wr_valid && w_wr_ready) begin
                        w_mem_we     = 1'b1;
                        w_post_count = r_count + C_CNT_ONE;
                    end else begin
                        w_post_count = r_count;
                    end
                    w_next_count = w_post_count;
                    // A write landing in the same cycle as run joins the program.
                    if (run && (w_post_count != {(PTR_W+1){1'b0}})) begin
                        w_next_state = ST_RUN;
                        w_next_pc    = {PTR_W{1'b0}};
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        w_next_out   = w_rdata;
                        w_next_valid = 1'b1;
                        if (w_last) begin
                            w_next_pc = {PTR_W{1'b0}};
                            if (loop_en) begin
                                w_next_state = ST_RUN;
                            end else begin
                                w_next_state = ST_DONE;
                            end
                        end else begin
                            w_next_pc = r_pc + C_PC_ONE;
                        end
                    end else begin
                        w_next_pc = r_pc;
                    end
                end
                ST_DONE: begin
                    if (run) begin
                        w_next_state = ST_RUN;
                        w_next_pc    = {PTR_W{1'b0}};
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
                default: begin
                    w_next_state = ST_LOAD;
                    w_next_count = {(PTR_W+1){1'b0}};
                    w_next_pc    = {PTR_W{1'b0}};
                end
            endcase
        end
    end

    // State, pointer, count and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_LOAD;
            r_count       <= {(PTR_W+1){1'b0}};
            r_pc          <= {PTR_W{1'b0}};
            r_instr_out   <= IDLE_INSTR;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count       <= w_next_count;
            r_pc          <= w_next_pc;
            r_instr_out   <= w_next_out;
            r_instr_valid <= w_next_valid;
        end
    end

    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign count       = r_count;
    assign wr_ready    = w_wr_ready;

endmodule

// File: tb/tb_mccoy_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mccoy_instr_sequencer
// Directed scenarios plus randomized traffic, all checked each cycle against a
// queue-based program model, with a few extra checks against fixed constants.
// -----------------------------------------------------------------------------
module tb_mccoy_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset, wr_valid, run, loop_en, clear;
    logic [5:0] wr_instr;
    logic       wr_ready, instr_valid, busy, done;
    logic [5:0] instr_out;
    logic [3:0] count;
`ifdef MCCOY_SEQ_STEP_EN
    logic       step;
`endif

    always #5 clk = ~clk;

    mccoy_instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_instr    (wr_instr),
        .wr_ready    (wr_ready),
        .run         (run),
        .loop_en     (loop_en),
        .clear       (clear),
`ifdef MCCOY_SEQ_STEP_EN
        .step        (step),
`endif
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    int total = 0;
    int bad   = 0;

    // Model: program as a queue, a phase (0 load, 1 run, 2 done), issue index.
    logic [5:0] m_prog[$];
    int         m_mode = 0;
    int         m_idx  = 0;
    logic [5:0] m_out  = 6'd0;
    logic       m_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic st;
        st = 1'b1;
`ifdef MCCOY_SEQ_STEP_EN
        st = step;
`endif
        m_out   = 6'd0;
        m_valid = 1'b0;
        if (reset || clear) begin
            m_prog.delete();
            m_mode = 0;
            m_idx  = 0;
        end else if (m_mode == 0) begin
            if (wr_valid && m_prog.size() < 8) m_prog.push_back(wr_instr);
            if (run && m_prog.size() > 0) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end else if (m_mode == 1) begin
            if (st) begin
                m_out   = m_prog[m_idx];
                m_valid = 1'b1;
                if (m_idx == m_prog.size() - 1) begin
                    if (loop_en) m_idx = 0;
                    else m_mode = 2;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (run) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("instr_out", 32'(instr_out), 32'(m_out));
        check_val("instr_valid", 32'(instr_valid), 32'(m_valid));
        check_val("busy", 32'(busy), 32'(m_mode == 1));
        check_val("done", 32'(done), 32'(m_mode == 2));
        check_val("count", 32'(count), 32'(m_prog.size()));
        check_val("wr_ready", 32'(wr_ready), 32'((m_mode == 0) && (m_prog.size() < 8)));
    endtask

    task automatic quiet();
        reset = 1'b0; clear = 1'b0; wr_valid = 1'b0; run = 1'b0;
    endtask

    task automatic write_instr(input logic [5:0] v);
        wr_valid = 1'b1;
        wr_instr = v;
        tick();
        wr_valid = 1'b0;
    endtask

    logic [5:0] prog4 [4];
    int         guard;

    initial begin
        prog4[0] = 6'b011000; prog4[1] = 6'b010110;
        prog4[2] = 6'b010000; prog4[3] = 6'b010011;
        reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; run = 1'b0;
        loop_en = 1'b0; wr_instr = 6'd0;
`ifdef MCCOY_SEQ_STEP_EN
        step = 1'b1;
`endif
        tick();
        check_val("reset_out", 32'(instr_out), 32'h0);
        check_val("reset_count", 32'(count), 32'h0);
        quiet();

        // One-shot four-instruction program.
        for (int i = 0; i < 4; i++) write_instr(prog4[i]);
        run = 1'b1; loop_en = 1'b0;
        tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("oneshot_seq", 32'(instr_out), 32'(prog4[i]));
            check_val("oneshot_valid", 32'(instr_valid), 32'h1);
        end
        tick();
        check_val("oneshot_done", 32'(done), 32'h1);
        check_val("oneshot_idle", 32'(instr_valid), 32'h0);

        // Overfill: nine writes into an eight-entry buffer.
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            write_instr(6'(i + 1));
            if (i == 7) check_val("full_ready", 32'(wr_ready), 32'h0);
        end
        check_val("full_count", 32'(count), 32'h8);

        // Looped two-entry program, then loop_en dropped mid-pass.
        clear = 1'b1; tick(); clear = 1'b0;
        write_instr(6'b010000);
        write_instr(6'b011011);
        run = 1'b1; loop_en = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tick();
        loop_en = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        check_val("loop_exit_timeout", 32'(guard < 10), 32'h1);
        check_val("loop_exit_done", 32'(done), 32'h1);

        // run with an empty buffer, then run together with a single write.
        clear = 1'b1; tick(); clear = 1'b0;
        run = 1'b1; tick();
        check_val("empty_run_busy", 32'(busy), 32'h0);
        wr_valid = 1'b1; wr_instr = 6'b001101;
        tick();
        run = 1'b0; wr_valid = 1'b0;
        tick();
        check_val("single_issue", 32'(instr_out), 32'h0d);
        tick();
        check_val("single_done", 32'(done), 32'h1);

        // reset in the second RUN cycle, then clear from DONE.
        for (int i = 0; i < 3; i++) write_instr(prog4[i]);
        run = 1'b1; tick(); run = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("midrun_reset_valid", 32'(instr_valid), 32'h0);
        check_val("midrun_reset_out", 32'(instr_out), 32'h0);
        write_instr(6'b000101);
        run = 1'b1; tick(); run = 1'b0;
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("clear_ready", 32'(wr_ready), 32'h1);
        check_val("clear_count", 32'(count), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            wr_valid = $urandom_range(0, 1);
            wr_instr = 6'($urandom);
            run      = ($urandom_range(0, 5) == 0);
            loop_en  = ($urandom_range(0, 3) != 0);
`ifdef MCCOY_SEQ_STEP_EN
            step     = $urandom_range(0, 1);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
